// File: rtl/ps2_key_tracker.sv
// Consumer for the ps2_keyboard FIFO: pops scan-code bytes and decodes the F0/E0 prefixes.
// It tracks the held key, the shift state and a press counter, and translates the held key to ASCII.
module ps2_key_tracker #(
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         data,
  input  logic               ready,
  input  logic               overflow,
  output logic               nextdata_n,
  output logic               key_down,
  output logic [7:0]         scancode,
  output logic               ext,
  output logic [7:0]         ascii,
  output logic               shift,
  output logic [COUNT_W-1:0] press_count,
  output logic               err,
  output logic               state_dbg
);

  // Handshake: a byte is consumed in a FETCH cycle with ready=1. nextdata_n drops
  // combinationally in that same cycle. The GAP cycle that follows lets the FIFO
  // read pointer settle, so nextdata_n is never low on two consecutive cycles.
  typedef enum logic {FETCH = 1'b0, GAP = 1'b1} state_t;

  state_t state_q, state_d;
  logic               consume;
  logic               brk_q, brk_d;
  logic               pend_ext_q, pend_ext_d;
  logic               key_down_q, key_down_d;
  logic [7:0]         scancode_q, scancode_d;
  logic               ext_q, ext_d;
  logic [7:0]         ascii_q, ascii_d;
  logic               shift_q, shift_d;
  logic [COUNT_W-1:0] press_count_q, press_count_d;
  logic               err_q, err_d;
  logic               same_key;

  function automatic logic [7:0] lookup(input logic [7:0] code, input logic is_ext,
                                        input logic shifted);
    logic [7:0] letter;
    logic [7:0] other;
    letter = 8'h00;
    other  = 8'h00;
    case (code)
      8'h1C: letter = 8'h61; 8'h32: letter = 8'h62; 8'h21: letter = 8'h63;
      8'h23: letter = 8'h64; 8'h24: letter = 8'h65; 8'h2B: letter = 8'h66;
      8'h34: letter = 8'h67; 8'h33: letter = 8'h68; 8'h43: letter = 8'h69;
      8'h3B: letter = 8'h6A; 8'h42: letter = 8'h6B; 8'h4B: letter = 8'h6C;
      8'h3A: letter = 8'h6D; 8'h31: letter = 8'h6E; 8'h44: letter = 8'h6F;
      8'h4D: letter = 8'h70; 8'h15: letter = 8'h71; 8'h2D: letter = 8'h72;
      8'h1B: letter = 8'h73; 8'h2C: letter = 8'h74; 8'h3C: letter = 8'h75;
      8'h2A: letter = 8'h76; 8'h1D: letter = 8'h77; 8'h22: letter = 8'h78;
      8'h35: letter = 8'h79; 8'h1A: letter = 8'h7A;
      8'h45: other = 8'h30; 8'h16: other = 8'h31; 8'h1E: other = 8'h32;
      8'h26: other = 8'h33; 8'h25: other = 8'h34; 8'h2E: other = 8'h35;
      8'h36: other = 8'h36; 8'h3D: other = 8'h37; 8'h3E: other = 8'h38;
      8'h46: other = 8'h39;
      8'h29: other = 8'h20; 8'h5A: other = 8'h0D; 8'h66: other = 8'h08;
      default: begin
        letter = 8'h00;
        other  = 8'h00;
      end
    endcase
    if (is_ext)
      return 8'h00;
    else if (letter != 8'h00)
      return shifted ? (letter - 8'h20) : letter;
    else
      return other;
  endfunction

  always_comb begin
    state_d    = state_q;
    nextdata_n = 1'b1;
    consume    = 1'b0;
    case (state_q)
      FETCH: if (ready) begin
        nextdata_n = 1'b0;
        consume    = 1'b1;
        state_d    = GAP;
      end
      GAP:     state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  assign same_key = key_down_q && (data == scancode_q) && (pend_ext_q == ext_q);

  always_comb begin
    brk_d         = brk_q;
    pend_ext_d    = pend_ext_q;
    key_down_d    = key_down_q;
    scancode_d    = scancode_q;
    ext_d         = ext_q;
    ascii_d       = ascii_q;
    shift_d       = shift_q;
    press_count_d = press_count_q;
    err_d         = err_q | overflow;
    if (consume) begin
      if (data == 8'hF0) begin
        brk_d = 1'b1;
      end else if (data == 8'hE0) begin
        pend_ext_d = 1'b1;
      end else if ((data == 8'h12 || data == 8'h59) && !pend_ext_q) begin
        shift_d = ~brk_q;
        brk_d   = 1'b0;
      end else if (brk_q) begin
        if (same_key) begin
          key_down_d = 1'b0;
          ascii_d    = 8'h00;
        end
        brk_d      = 1'b0;
        pend_ext_d = 1'b0;
      end else begin
        // A repeat of the held key is typematic and must not count as a new press.
        if (!same_key) begin
          scancode_d    = data;
          ext_d         = pend_ext_q;
          key_down_d    = 1'b1;
          press_count_d = press_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
          ascii_d       = lookup(data, pend_ext_q, shift_q);
        end
        pend_ext_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FETCH;
      brk_q         <= 1'b0;
      pend_ext_q    <= 1'b0;
      key_down_q    <= 1'b0;
      scancode_q    <= 8'h00;
      ext_q         <= 1'b0;
      ascii_q       <= 8'h00;
      shift_q       <= 1'b0;
      press_count_q <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      brk_q         <= brk_d;
      pend_ext_q    <= pend_ext_d;
      key_down_q    <= key_down_d;
      scancode_q    <= scancode_d;
      ext_q         <= ext_d;
      ascii_q       <= ascii_d;
      shift_q       <= shift_d;
      press_count_q <= press_count_d;
      err_q         <= err_d;
    end
  end

  assign key_down    = key_down_q;
  assign scancode    = scancode_q;
  assign ext         = ext_q;
  assign ascii       = ascii_q;
  assign shift       = shift_q;
  assign press_count = press_count_q;
  assign err         = err_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: feeds scan-code sequences through the FIFO handshake
// and compares the tracked key state against hand-computed values.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       ready;
  logic       overflow;
  logic       nextdata_n;
  logic       key_down;
  logic [7:0] scancode;
  logic       ext;
  logic [7:0] ascii;
  logic       shift;
  logic [7:0] press_count;
  logic       err;
  logic       state_dbg;

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;
  int b2b_cnt   = 0;
  logic prev_low = 1'b0;

  ps2_key_tracker #(.COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nextdata_n), .key_down(key_down), .scancode(scancode), .ext(ext),
    .ascii(ascii), .shift(shift), .press_count(press_count), .err(err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Pop-strobe monitor: counts low pulses and flags any two consecutive low cycles.
  always @(posedge clk) begin
    if (!rst) begin
      if (!nextdata_n) pulse_cnt++;
      if (!nextdata_n && prev_low) b2b_cnt++;
      prev_low = !nextdata_n;
    end else begin
      prev_low = 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ready = 1'b0; overflow = 1'b0; data = 8'h00;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one byte with ready held high until popped, then drops ready.
  task automatic send_byte(input logic [7:0] b);
    bit popped = 1'b0;
    @(negedge clk);
    data = b; ready = 1'b1;
    #1;
    for (int i = 0; i < 8; i++) begin
      if (nextdata_n === 1'b0) begin
        popped = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    if (!popped) begin
      checks++; failures++;
      $display("FAIL pop_timeout: byte %h not popped within 8 cycles", b);
      ready = 1'b0;
    end else begin
      @(posedge clk); #1;
      ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL rst_key_down: got %b expected 0", key_down); end
    checks++; if (scancode !== 8'h00) begin failures++; $display("FAIL rst_scancode: got %h expected 00", scancode); end
    checks++; if (ascii !== 8'h00) begin failures++; $display("FAIL rst_ascii: got %h expected 00", ascii); end
    checks++; if ({ext, shift, err} !== 3'b000) begin failures++; $display("FAIL rst_flags: got %b expected 000", {ext, shift, err}); end
    checks++; if (press_count !== 8'd0) begin failures++; $display("FAIL rst_count: got %0d expected 0", press_count); end
    checks++; if (nextdata_n !== 1'b1) begin failures++; $display("FAIL rst_nextdata_n: got %b expected 1", nextdata_n); end
    checks++; if (state_dbg !== 1'b0) begin failures++; $display("FAIL rst_state: got %b expected FETCH", state_dbg); end
  endtask

  task automatic test_press_release();
    do_reset();
    pulse_cnt = 0; b2b_cnt = 0;
    send_byte(8'h1C);
    checks++; if (state_dbg !== 1'b1 || nextdata_n !== 1'b1) begin failures++; $display("FAIL pr_gap: state=%b nextdata_n=%b expected GAP,1", state_dbg, nextdata_n); end
    checks++; if ({key_down, scancode, ascii, press_count} !== {1'b1, 8'h1C, 8'h61, 8'd1}) begin failures++; $display("FAIL pr_make: got kd=%b sc=%h asc=%h pc=%0d expected 1 1c 61 1", key_down, scancode, ascii, press_count); end
    send_byte(8'hF0);
    send_byte(8'h1C);
    checks++; if ({key_down, ascii, press_count} !== {1'b0, 8'h00, 8'd1}) begin failures++; $display("FAIL pr_break: got kd=%b asc=%h pc=%0d expected 0 00 1", key_down, ascii, press_count); end
    @(negedge clk);
    checks++; if (pulse_cnt !== 3) begin failures++; $display("FAIL pr_pulses: got %0d expected 3", pulse_cnt); end
    checks++; if (b2b_cnt !== 0) begin failures++; $display("FAIL pr_b2b: got %0d expected 0", b2b_cnt); end
  endtask

  task automatic test_shift();
    do_reset();
    send_byte(8'h12);
    checks++; if (shift !== 1'b1) begin failures++; $display("FAIL sh_on: got %b expected 1", shift); end
    checks++; if (key_down !== 1'b0 || press_count !== 8'd0) begin failures++; $display("FAIL sh_nokey: kd=%b pc=%0d expected 0 0", key_down, press_count); end
    send_byte(8'h1C);
    checks++; if (ascii !== 8'h41) begin failures++; $display("FAIL sh_upper: got %h expected 41", ascii); end
    send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12);
    checks++; if ({shift, key_down, press_count} !== {1'b0, 1'b0, 8'd1}) begin failures++; $display("FAIL sh_end: shift=%b kd=%b pc=%0d expected 0 0 1", shift, key_down, press_count); end
  endtask

  task automatic test_ascii();
    do_reset();
    send_byte(8'h59);
    send_byte(8'h16);
    checks++; if (ascii !== 8'h31) begin failures++; $display("FAIL as_digit_shift: got %h expected 31", ascii); end
    send_byte(8'hF0); send_byte(8'h59);
    send_byte(8'h29);
    checks++; if (ascii !== 8'h20) begin failures++; $display("FAIL as_space: got %h expected 20", ascii); end
    send_byte(8'h5A);
    checks++; if (ascii !== 8'h0D) begin failures++; $display("FAIL as_enter: got %h expected 0d", ascii); end
    send_byte(8'h66);
    checks++; if (ascii !== 8'h08) begin failures++; $display("FAIL as_bksp: got %h expected 08", ascii); end
    send_byte(8'h76);
    checks++; if ({key_down, ascii, press_count} !== {1'b1, 8'h00, 8'd5}) begin failures++; $display("FAIL as_unmapped: kd=%b asc=%h pc=%0d expected 1 00 5", key_down, ascii, press_count); end
    send_byte(8'h1A);
    send_byte(8'h12);
    checks++; if (ascii !== 8'h7A || shift !== 1'b1) begin failures++; $display("FAIL as_latch: asc=%h shift=%b expected 7a 1", ascii, shift); end
  endtask

  task automatic test_typematic();
    do_reset();
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    checks++; if (press_count !== 8'd1) begin failures++; $display("FAIL tm_repeat: got %0d expected 1", press_count); end
    send_byte(8'h32);
    checks++; if ({scancode, ascii, press_count, key_down} !== {8'h32, 8'h62, 8'd2, 1'b1}) begin failures++; $display("FAIL tm_new: sc=%h asc=%h pc=%0d kd=%b expected 32 62 2 1", scancode, ascii, press_count, key_down); end
  endtask

  task automatic test_extended();
    do_reset();
    send_byte(8'hE0); send_byte(8'h75);
    checks++; if ({ext, ascii, press_count, scancode} !== {1'b1, 8'h00, 8'd1, 8'h75}) begin failures++; $display("FAIL ex_make: ext=%b asc=%h pc=%0d sc=%h expected 1 00 1 75", ext, ascii, press_count, scancode); end
    send_byte(8'hF0); send_byte(8'h75);
    checks++; if (key_down !== 1'b1) begin failures++; $display("FAIL ex_plain_break: got %b expected 1", key_down); end
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    checks++; if (key_down !== 1'b0) begin failures++; $display("FAIL ex_break: got %b expected 0", key_down); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    b2b_cnt = 0;
    @(negedge clk);
    data = 8'h1C; ready = 1'b1;
    #1;
    checks++; if (nextdata_n !== 1'b0) begin failures++; $display("FAIL bb_pop1: got %b expected 0", nextdata_n); end
    @(posedge clk); #1;
    data = 8'h32;
    checks++; if (nextdata_n !== 1'b1 || state_dbg !== 1'b1) begin failures++; $display("FAIL bb_gap: nextdata_n=%b state=%b expected 1 GAP", nextdata_n, state_dbg); end
    @(posedge clk); #1;
    checks++; if (nextdata_n !== 1'b0 || scancode !== 8'h1C) begin failures++; $display("FAIL bb_pop2: nextdata_n=%b sc=%h expected 0 1c", nextdata_n, scancode); end
    @(posedge clk); #1;
    ready = 1'b0;
    checks++; if ({scancode, press_count} !== {8'h32, 8'd2}) begin failures++; $display("FAIL bb_result: sc=%h pc=%0d expected 32 2", scancode, press_count); end
    checks++; if (b2b_cnt !== 0) begin failures++; $display("FAIL bb_b2b: got %0d expected 0", b2b_cnt); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 255; i++) send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
    checks++; if (press_count !== 8'd255) begin failures++; $display("FAIL wr_255: got %0d expected 255", press_count); end
    send_byte(8'h32);
    checks++; if (press_count !== 8'd0) begin failures++; $display("FAIL wr_zero: got %0d expected 0", press_count); end
  endtask

  task automatic test_overflow_reset();
    do_reset();
    send_byte(8'h1C);
    @(negedge clk); overflow = 1'b1;
    @(negedge clk); overflow = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL ov_set: got %b expected 1", err); end
    send_byte(8'h32);
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({err, scancode, press_count} !== {1'b1, 8'h32, 8'd2}) begin failures++; $display("FAIL ov_sticky: err=%b sc=%h pc=%0d expected 1 32 2", err, scancode, press_count); end
    send_byte(8'hF0);
    do_reset();
    send_byte(8'h1C);
    checks++; if ({err, key_down, press_count, ascii} !== {1'b0, 1'b1, 8'd1, 8'h61}) begin failures++; $display("FAIL ov_rst_make: err=%b kd=%b pc=%0d asc=%h expected 0 1 1 61", err, key_down, press_count, ascii); end
  endtask

  initial begin
    rst = 1'b1; ready = 1'b0; overflow = 1'b0; data = 8'h00;
    test_reset();
    test_press_release();
    test_shift();
    test_ascii();
    test_typematic();
    test_extended();
    test_back_to_back();
    test_wrap();
    test_overflow_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
